uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Parametrised UART transmit serializer, successor to the eUSCI fixed 7/8-bit transmit state machine. It adds a runtime-selectable character length up to `MAX_DATA_BITS`, a small transmit FIFO for back-to-back frames, an overflow flag and break generation. It runs entirely on the bit-rate clock `BITCLK` and drives the `Tx` pin. Interrupt-flag pulses go to the eUSCI flag register.

## Interface
- `MAX_DATA_BITS`, 9: widest character supported; legal range 5–9.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, minimum 2.
- `BITCLK`  in  1  bit-rate clock; one bit period per rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cfgBits`  in  4  character length; values below 5 act as 5, values above `MAX_DATA_BITS` act as `MAX_DATA_BITS`.
- `cfgPEN`  in  1  parity enable.
- `cfgPAR`  in  1  1 = even parity, 0 = odd parity.
- `cfgMSB`  in  1  1 = MSB first.
- `cfgSPB`  in  1  1 = two stop bits.
- `cfgBRK`  in  1  request break (hold line low).
- `wrEn`  in  1  push `wrData` into the FIFO on this edge.
- `wrData`  in  MAX_DATA_BITS  character; bits at or above the effective length are ignored.
- `fifoLevel`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `fifoFull`  out  1  `fifoLevel == FIFO_DEPTH`.
- `setTXIFG`  out  1  one-cycle pulse: a word was popped and the FIFO has room.
- `setTXCPTIFG`  out  1  one-cycle pulse: last stop bit with nothing queued.
- `setOVR`  out  1  one-cycle pulse: a write was dropped.
- `TxBusy`  out  1  state ≠ IDLE.
- `Tx`  out  1  serial output, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP2, STOP1, BREAK, BRKMARK.
- `Tx` is the registered value for the state being entered: START→0; DATA→current bit; PARITY→parity; STOP2/STOP1/IDLE/BRKMARK→1; BREAK→0.
- IDLE:
  - If `cfgBRK` → BREAK.
  - Else if the FIFO is non-empty → START.
  - Else stay in IDLE.
- Entering START:
  - Pop the FIFO head.
  - Latch the effective length, PEN, PAR, MSB and SPB into frame registers. Config changes mid-frame do not affect the frame in flight.
  - Load the shift register.
  - Clear the bit counter.
- DATA:
  - Lasts exactly the effective length in cycles.
  - Bit order is LSB-first, or bit[len-1] down to bit 0 when MSB is set.
  - After the last bit: PARITY if PEN; else STOP2 if SPB; else STOP1.
- PARITY:
  - Even mode: the bit equals XOR of the transmitted bits.
  - Odd mode: the bit is its complement.
  - Next state is STOP2 if SPB, else STOP1.
- STOP2 → STOP1.
- STOP1: next state is BREAK if `cfgBRK`; else START if the FIFO is non-empty or `wrEn` is high this cycle; else IDLE.
- BREAK: hold `Tx`=0 while `cfgBRK` is high; on deassert → BRKMARK (one cycle `Tx`=1) → IDLE. The FIFO is untouched.
- FIFO:
  - A write with the FIFO not full is accepted.
  - A write when full is accepted only if a pop occurs on the same edge; otherwise it is dropped and `setOVR` pulses.
  - A simultaneous write and pop leaves the level unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A write into an empty FIFO during IDLE is poppable on the next edge.
- Flags:
  - `setTXIFG` is high for the one cycle after any pop (state==START).
  - `setTXCPTIFG` is high during STOP1 when `fifoLevel==0` and `wrEn==0`.
  - Both flags are low in BREAK and BRKMARK.
- Reset (any time, including mid-frame):
  - `Tx`=1 immediately.
  - State=IDLE, FIFO emptied, `fifoLevel`=0.
  - All flags 0, `TxBusy`=0.
  - Shift register and frame registers cleared.

## Timing
- Write→first start bit: a write at edge n while IDLE puts `Tx`=0 from edge n+1.
- Frame length in cycles = 1 + len + PEN + (1 + SPB).
- Back-to-back frames: no idle bit between STOP1 and the next START when a word is queued.
- Maximum frame is 13 cycles (9 data bits, parity, 2 stop bits); minimum is 7 cycles.
- `fifoLevel` and `fifoFull` update on the same edge as the push or pop.
- `setOVR` is asserted in the cycle after the dropped write edge.

## Test plan
- Reset, then idle 5 cycles → `Tx`=1, `TxBusy`=0, `fifoLevel`=0, all flags 0.
- len=8, no parity, 1 stop, LSB first, write 0xA5 → `Tx` sequence 0,1,0,1,0,0,1,0,1,1 across 10 cycles; `setTXIFG` in cycle 1; `setTXCPTIFG` in cycle 10; then IDLE.
- len=9, even parity, 2 stop, MSB first, write 0x1C3 → 0,1,1,1,0,0,0,0,1,1,1,1,1 across 13 cycles (parity=1 because five ones are sent).
- len=7, odd parity, write 0x55 and 0x2A back-to-back → second start bit immediately follows the first frame's stop bit; `setTXIFG` pulses twice; `setTXCPTIFG` pulses once, at the end.
- `FIFO_DEPTH`=4 while the line is busy: write 5 words with no pop → `fifoFull`=1 after the 4th write; the 5th write is dropped and `setOVR`=1 for one cycle; a write on the pop edge with the FIFO full is accepted and the level stays 4.
- Mid-frame checks:
  - Assert `cfgBRK` during DATA → the frame completes, then `Tx`=0 while `cfgBRK` is held, then one mark cycle, then IDLE.
  - Assert `reset` in bit 4 of a frame → `Tx`=1 immediately and the FIFO is empty.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit serializer running on the bit-rate clock. Characters are queued
// in a small FIFO and sent as: start bit, 5..MAX_DATA_BITS data bits (LSB or
// MSB first), optional even/odd parity, then one or two stop bits. Frames are
// sent back-to-back while words are queued. A break request holds the line low
// until it is released, then one mark bit is sent before returning to idle.
//
// Parameters
//   MAX_DATA_BITS  widest character supported (5..9)
//   FIFO_DEPTH     transmit FIFO entries (power of two, >= 2)
//
// Ports
//   BITCLK       in   bit-rate clock, one bit period per rising edge
//   reset        in   asynchronous, active-high
//   cfgBits      in   character length (clamped to 5..MAX_DATA_BITS)
//   cfgPEN       in   parity enable
//   cfgPAR       in   1 = even parity, 0 = odd parity
//   cfgMSB       in   1 = MSB first
//   cfgSPB       in   1 = two stop bits
//   cfgBRK       in   break request (hold line low)
//   wrEn         in   push wrData into the FIFO on this edge
//   wrData       in   character; bits at or above the length are ignored
//   fifoLevel    out  occupied FIFO entries
//   fifoFull     out  FIFO holds FIFO_DEPTH entries
//   setTXIFG     out  one-cycle pulse in the cycle after a pop
//   setTXCPTIFG  out  one-cycle pulse on the last stop bit with nothing queued
//   setOVR       out  one-cycle pulse in the cycle after a dropped write
//   TxBusy       out  serializer not idle
//   Tx           out  registered serial output
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          BITCLK,
  input  logic                          reset,
  input  logic [3:0]                    cfgBits,
  input  logic                          cfgPEN,
  input  logic                          cfgPAR,
  input  logic                          cfgMSB,
  input  logic                          cfgSPB,
  input  logic                          cfgBRK,
  input  logic                          wrEn,
  input  logic [MAX_DATA_BITS-1:0]      wrData,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          fifoFull,
  output logic                          setTXIFG,
  output logic                          setTXCPTIFG,
  output logic                          setOVR,
  output logic                          TxBusy,
  output logic                          Tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       MIN_LEN  = 4'd5;
  localparam logic [3:0]       MAX_LEN  = 4'(MAX_DATA_BITS);

  // Line states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP2   = 3'd4;
  localparam logic [2:0] S_STOP1   = 3'd5;
  localparam logic [2:0] S_BREAK   = 3'd6;
  localparam logic [2:0] S_BRKMARK = 3'd7;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]               state_q, state_d;
  logic                     tx_q, tx_d;
  logic                     ovr_q, ovr_d;

  // Frame registers, captured when a word is popped
  logic [3:0]               len_q;
  logic                     pen_q;
  logic                     spb_q;
  logic                     parity_q;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;

  // FIFO
  logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]         level_q, level_d;

  // ---------------------------------------------------------------------------
  // FIFO status and push/pop decisions
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);

  // A pop happens exactly on the edge that enters START.
  assign pop  = (state_d == S_START);
  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign push = wrEn && (!fifo_full || pop);
  assign drop = wrEn && fifo_full && !pop;

  // When STOP1 chains straight into a new frame with the FIFO empty, the word
  // being written on this edge is the one sent, so it bypasses the storage.
  logic [MAX_DATA_BITS-1:0] head_data;
  assign head_data = fifo_empty ? wrData : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Character preparation for the word being popped
  // ---------------------------------------------------------------------------
  logic [3:0]               len_eff;
  logic [MAX_DATA_BITS-1:0] data_mask;
  logic [MAX_DATA_BITS-1:0] data_masked;
  logic [MAX_DATA_BITS-1:0] data_rev_full;
  logic [MAX_DATA_BITS-1:0] data_load;
  logic                     parity_load;

  always_comb begin
    if (cfgBits < MIN_LEN) begin
      len_eff = MIN_LEN;
    end else if (cfgBits > MAX_LEN) begin
      len_eff = MAX_LEN;
    end else begin
      len_eff = cfgBits;
    end
  end

  assign data_mask     = ~({MAX_DATA_BITS{1'b1}} << len_eff);
  assign data_masked   = head_data & data_mask;
  // Full-width reversal followed by a right shift leaves bit[len-1] in bit 0,
  // so MSB-first frames can share the LSB-first shifter.
  assign data_rev_full = {<<{data_masked}};
  assign data_load     = cfgMSB ? (data_rev_full >> (MAX_LEN - len_eff)) : data_masked;
  // Even parity is the XOR of the sent bits; odd parity is its complement.
  assign parity_load   = (^data_masked) ^ ~cfgPAR;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic last_data_bit;
  assign last_data_bit = (bit_cnt_q == (len_q - 4'd1));

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfgBRK) begin
          state_d = S_BREAK;
        end else if (!fifo_empty) begin
          state_d = S_START;
        end
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        if (last_data_bit) begin
          if (pen_q) begin
            state_d = S_PARITY;
          end else begin
            state_d = spb_q ? S_STOP2 : S_STOP1;
          end
        end
      end
      S_PARITY: state_d = spb_q ? S_STOP2 : S_STOP1;
      S_STOP2:  state_d = S_STOP1;
      S_STOP1: begin
        if (cfgBRK) begin
          state_d = S_BREAK;
        end else if (!fifo_empty || wrEn) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BREAK:   state_d = cfgBRK ? S_BREAK : S_BRKMARK;
      S_BRKMARK: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Shifter and bit counter: loaded on the pop, advanced on every edge that
  // enters or stays in DATA (the bit leaving position 0 goes onto the line).
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (pop) begin
      shift_d   = data_load;
      bit_cnt_d = 4'd0;
    end else if (state_d == S_DATA) begin
      shift_d = shift_q >> 1;
      if (state_q == S_DATA) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  // The line level is registered for the state being entered.
  always_comb begin
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = parity_q;
      S_BREAK:  tx_d = 1'b0;
      default:  tx_d = 1'b1;
    endcase
  end

  assign ovr_d = drop;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge BITCLK or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (reset) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      ovr_q     <= 1'b0;
      len_q     <= '0;
      pen_q     <= 1'b0;
      spb_q     <= 1'b0;
      parity_q  <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      ovr_q     <= ovr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      level_q   <= level_d;
      if (pop) begin
        // Config is frozen here so mid-frame changes do not disturb the frame.
        len_q    <= len_eff;
        pen_q    <= cfgPEN;
        spb_q    <= cfgSPB;
        parity_q <= parity_load;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: the FIFO storage has no reset; emptiness is tracked by the pointers
  // and level, so stale contents are never observed.
  always_ff @(posedge BITCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wrData;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Tx          = tx_q;
  assign TxBusy      = (state_q != S_IDLE);
  assign fifoLevel   = level_q;
  assign fifoFull    = fifo_full;
  assign setOVR      = ovr_q;
  assign setTXIFG    = (state_q == S_START);
  assign setTXCPTIFG = (state_q == S_STOP1) && fifo_empty && !wrEn;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Self-checking bench for uart_tx_serializer. A behavioural model keeps the
// queued words in a queue and, when a frame starts, expands the character
// into the list of line bits it must produce; each cycle the DUT outputs are
// compared with the model. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int MAXB  = 9;
  localparam int DEPTH = 4;

  logic            BITCLK = 1'b0;
  logic            reset;
  logic [3:0]      cfgBits;
  logic            cfgPEN, cfgPAR, cfgMSB, cfgSPB, cfgBRK;
  logic            wrEn;
  logic [MAXB-1:0] wrData;
  logic [2:0]      fifoLevel;
  logic            fifoFull, setTXIFG, setTXCPTIFG, setOVR, TxBusy, Tx;

  uart_tx_serializer #(.MAX_DATA_BITS(MAXB), .FIFO_DEPTH(DEPTH)) dut (
    .BITCLK      (BITCLK),
    .reset       (reset),
    .cfgBits     (cfgBits),
    .cfgPEN      (cfgPEN),
    .cfgPAR      (cfgPAR),
    .cfgMSB      (cfgMSB),
    .cfgSPB      (cfgSPB),
    .cfgBRK      (cfgBRK),
    .wrEn        (wrEn),
    .wrData      (wrData),
    .fifoLevel   (fifoLevel),
    .fifoFull    (fifoFull),
    .setTXIFG    (setTXIFG),
    .setTXCPTIFG (setTXCPTIFG),
    .setOVR      (setOVR),
    .TxBusy      (TxBusy),
    .Tx          (Tx)
  );

  always #5 BITCLK = ~BITCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // mode: 0 idle, 1 sending a frame, 2 break, 3 mark after break
  // ---------------------------------------------------------------------------
  int              m_mode;
  bit              m_bits[$];   // line bits still to come in this frame
  bit              m_tx;
  bit              m_ifg;
  bit              m_ovr;
  logic [MAXB-1:0] m_q[$];

  function automatic void model_reset();
    m_q.delete();
    m_bits.delete();
    m_mode = 0;
    m_tx   = 1'b1;
    m_ifg  = 1'b0;
    m_ovr  = 1'b0;
  endfunction

  function automatic void build_frame(input logic [MAXB-1:0] w);
    int len = int'(cfgBits);
    int ones = 0;
    logic [MAXB-1:0] tmp;
    if (len < 5) len = 5;
    if (len > MAXB) len = MAXB;
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int k = 0; k < len; k++) begin
      int idx = cfgMSB ? (len - 1 - k) : k;
      tmp = w >> idx;
      ones += int'(tmp[0]);
      m_bits.push_back(tmp[0]);
    end
    if (cfgPEN) m_bits.push_back(cfgPAR ? bit'(ones % 2) : bit'(1 - ones % 2));
    if (cfgSPB) m_bits.push_back(1'b1);
    m_bits.push_back(1'b1);
  endfunction

  function automatic void model_step();
    bit pop = 1'b0;
    int sz  = m_q.size();
    m_ifg = 1'b0;
    if (m_mode == 1 && m_bits.size() > 0) begin
      m_tx = m_bits.pop_front();
    end else if (m_mode == 2) begin
      if (cfgBRK) m_tx = 1'b0;
      else begin m_mode = 3; m_tx = 1'b1; end
    end else if (m_mode == 3) begin
      m_mode = 0;
      m_tx   = 1'b1;
    end else begin
      // idle, or the last stop bit of a frame has just been sent
      if (cfgBRK) begin
        m_mode = 2;
        m_tx   = 1'b0;
      end else if (sz > 0 || (m_mode == 1 && wrEn)) begin
        pop = 1'b1;
        build_frame(sz > 0 ? m_q[0] : wrData);
        m_mode = 1;
        m_ifg  = 1'b1;
        m_tx   = m_bits.pop_front();
      end else begin
        m_mode = 0;
        m_tx   = 1'b1;
      end
    end
    m_ovr = 1'b0;
    if (pop && sz > 0) void'(m_q.pop_front());
    if (wrEn) begin
      if (sz < DEPTH || pop) begin
        if (!(pop && sz == 0)) m_q.push_back(wrData);
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle comparison and stimulus helpers
  // ---------------------------------------------------------------------------
  logic [15:0] cap;
  int          cnt_ifg, cnt_cpt;

  task automatic compare_all();
    bit exp_cpt = (m_mode == 1) && (m_bits.size() == 0) && (m_q.size() == 0) && !wrEn;
    check("Tx",          32'(Tx),          32'(m_tx));
    check("TxBusy",      32'(TxBusy),      32'(m_mode != 0));
    check("fifoLevel",   32'(fifoLevel),   32'(m_q.size()));
    check("fifoFull",    32'(fifoFull),    32'(m_q.size() == DEPTH));
    check("setTXIFG",    32'(setTXIFG),    32'(m_ifg));
    check("setTXCPTIFG", 32'(setTXCPTIFG), 32'(exp_cpt));
    check("setOVR",      32'(setOVR),      32'(m_ovr));
    cap = {cap[14:0], Tx};
    cnt_ifg += int'(setTXIFG);
    cnt_cpt += int'(setTXCPTIFG);
  endtask

  // Drive inputs for the next edge, compare on the falling edge, step the model
  // on the rising edge, and return just after it.
  task automatic cyc(input logic wr, input logic [MAXB-1:0] d);
    wrEn   = wr;
    wrData = d;
    @(negedge BITCLK);
    compare_all();
    @(posedge BITCLK);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic pen, input logic par,
                         input logic msb, input logic spb);
    cfgBits = b; cfgPEN = pen; cfgPAR = par; cfgMSB = msb; cfgSPB = spb;
  endtask

  task automatic do_reset();
    wrEn   = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_Tx",     32'(Tx),        32'd1);
    check("rst_level",  32'(fifoLevel), 32'd0);
    check("rst_busy",   32'(TxBusy),    32'd0);
    check("rst_ifg",    32'(setTXIFG),  32'd0);
    check("rst_ovr",    32'(setOVR),    32'd0);
    model_reset();
    @(posedge BITCLK);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    cfgBRK = 1'b0;
    wrEn = 1'b0;
    wrData = '0;
    cap = '0;
    cnt_ifg = 0;
    cnt_cpt = 0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge BITCLK);
    #1;
    do_reset();

    // Idle after reset
    idle(5);

    // 8N1 LSB first, 0xA5
    cyc(1'b1, 9'h0A5);
    idle(11);
    check("frame_A5", 32'(cap[9:0]), 32'b0101001011);
    idle(3);

    // 9 bits, even parity, two stops, MSB first, 0x1C3
    set_cfg(4'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 9'h1C3);
    idle(14);
    check("frame_1C3", 32'(cap[12:0]), 32'b0111000011111);
    idle(3);

    // 7 bits, odd parity, back-to-back frames
    set_cfg(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cnt_ifg = 0;
    cnt_cpt = 0;
    cyc(1'b1, 9'h055);
    cyc(1'b1, 9'h02A);
    idle(24);
    check("b2b_ifg_count", 32'(cnt_ifg), 32'd2);
    check("b2b_cpt_count", 32'(cnt_cpt), 32'd1);

    // FIFO fill and overflow while a 13-cycle frame is on the line
    set_cfg(4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 9'h111);
    idle(1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 9'(i + 1));
    check("full_level", 32'(fifoLevel), 32'd4);
    check("full_flag",  32'(fifoFull),  32'd1);
    check("ovr_pulse",  32'(setOVR),    32'd1);
    // Keep writing across the pop edge: that write is accepted, level stays 4
    for (int i = 0; i < 12; i++) cyc(1'b1, 9'h1F0 + 9'(i));
    check("full_after_pop", 32'(fifoLevel), 32'd4);
    idle(80);

    // Break requested during the data bits
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h03C);
    idle(4);
    cfgBRK = 1'b1;
    idle(14);
    check("brk_line_low", 32'(Tx), 32'd0);
    cfgBRK = 1'b0;
    idle(4);
    check("brk_back_idle", 32'(TxBusy), 32'd0);

    // Reset in the middle of a frame with a word still queued
    cyc(1'b1, 9'h000);
    cyc(1'b1, 9'h0FF);
    idle(4);
    do_reset();
    check("mid_rst_level", 32'(fifoLevel), 32'd0);
    idle(4);

    // Random traffic with config churn, breaks and occasional resets
    begin
      int brk_left = 0;
      int rate = 3;
      for (int i = 0; i < 5000; i++) begin
        if (i % 250 == 0) rate = $urandom_range(1, 14);
        cfgBits = 4'($urandom_range(0, 15));
        cfgPEN  = 1'($urandom);
        cfgPAR  = 1'($urandom);
        cfgMSB  = 1'($urandom);
        cfgSPB  = 1'($urandom);
        if (brk_left > 0) begin
          cfgBRK = 1'b1;
          brk_left--;
        end else begin
          cfgBRK = 1'b0;
          if ($urandom_range(0, 299) == 0) brk_left = $urandom_range(1, 20);
        end
        if ($urandom_range(0, 999) == 0) begin
          do_reset();
        end else begin
          cyc(($urandom_range(0, rate) == 0), 9'($urandom));
        end
      end
      cfgBRK = 1'b0;
      idle(60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
